commu_m_regbank: RTL

//  Parametrised fx-bus register bank for a comm module; successor to the fixed 8-bit cfg/dbg file.

---
 rtl/commu_m_regbank.sv | 136 +++++++++++++
 1 files changed

// File: rtl/commu_m_regbank.sv
// fx-bus register bank for a comm module: cfg regs with update strobes, dbg regs,
// sticky W1C event status with mask/irq, and bus-activity counters.
module commu_m_regbank #(
    parameter int              DW      = 8,
    parameter int              N_CFG   = 4,
    parameter int              N_DBG   = 8,
    parameter logic [DW-1:0]   CFG_RST = '0,
    parameter logic [7:0]      VERSION = 8'h21
) (
    input  logic                clk_sys,
    input  logic                rst,
    input  logic                fx_wr,
    input  logic [15:0]         fx_waddr,
    input  logic [DW-1:0]       fx_data,
    input  logic                fx_rd,
    input  logic [15:0]         fx_raddr,
    output logic [DW-1:0]       fx_q,
    output logic                fx_q_vld,
    input  logic [5:0]          mod_id,
    output logic [N_CFG*DW-1:0] cfg_q,
    output logic [N_CFG-1:0]    cfg_upd,
    input  logic [DW-1:0]       evt_in,
    output logic                irq
);

    localparam logic [7:0] OFF_MOD_ID  = 8'h00;
    localparam logic [7:0] OFF_VERSION = 8'h01;
    localparam logic [7:0] OFF_EVT_STS = 8'hC0;
    localparam logic [7:0] OFF_EVT_MSK = 8'hC1;
    localparam logic [7:0] OFF_WR_CNT  = 8'hC2;
    localparam logic [7:0] OFF_RD_CNT  = 8'hC3;

    localparam logic [15:0] VERSION_X = {8'h00, VERSION};

    logic [DW-1:0] cfg_r [N_CFG];
    logic [DW-1:0] dbg_r [N_DBG];
    logic [DW-1:0] evt_sts;
    logic [DW-1:0] evt_msk;
    logic [DW-1:0] wr_cnt;
    logic [DW-1:0] rd_cnt;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] sts_clr;
    logic [15:0]   mod_id_x;
    logic [7:0]    woff;
    logic [7:0]    roff;
    logic          wsel;
    logic          rsel;

    assign wsel     = fx_wr && (fx_waddr[13:8] == mod_id);
    assign rsel     = fx_rd && (fx_raddr[13:8] == mod_id);
    assign woff     = fx_waddr[7:0];
    assign roff     = fx_raddr[7:0];
    assign mod_id_x = {10'b0, mod_id};
    assign sts_clr  = (wsel && woff == OFF_EVT_STS) ? fx_data : '0;

    function automatic logic [DW-1:0] dbg_rst_val(input int idx);
        logic [15:0] v;
        v = 16'(16'h0080 + idx);
        return v[DW-1:0];
    endfunction

    // NOTE: cfg/dbg are flop arrays with defined reset values, so unlike a RAM they are reset here.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CFG; i++) cfg_r[i] <= CFG_RST;
            for (int i = 0; i < N_DBG; i++) dbg_r[i] <= dbg_rst_val(i);
            cfg_upd <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            cfg_upd <= '0;
            for (int i = 0; i < N_CFG; i++) begin
                if (wsel && woff == 8'(64 + i)) begin
                    cfg_r[i]   <= fx_data;
                    cfg_upd[i] <= 1'b1;
                end
            end
            for (int i = 0; i < N_DBG; i++) begin
                if (wsel && woff == 8'(128 + i)) dbg_r[i] <= fx_data;
            end
        end
    end

    // Set beats clear: evt_in is OR'd in after the W1C mask is applied.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            evt_sts <= '0;
            evt_msk <= '0;
            irq     <= 1'b0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
        end else begin
            evt_sts <= (evt_sts & ~sts_clr) | evt_in;
            irq     <= |(evt_sts & evt_msk);
            if (wsel && woff == OFF_EVT_MSK) evt_msk <= fx_data;
            if (wsel) wr_cnt <= wr_cnt + DW'(1);
            if (rsel) rd_cnt <= rd_cnt + DW'(1);
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path through the mux infers a latch.
        rd_data = '0;
        case (roff)
            OFF_MOD_ID:  rd_data = mod_id_x[DW-1:0];
            OFF_VERSION: rd_data = VERSION_X[DW-1:0];
            OFF_EVT_STS: rd_data = evt_sts;
            OFF_EVT_MSK: rd_data = evt_msk;
            OFF_WR_CNT:  rd_data = wr_cnt;
            OFF_RD_CNT:  rd_data = rd_cnt;
            default:     rd_data = '0;
        endcase
        for (int i = 0; i < N_CFG; i++) begin
            if (roff == 8'(64 + i)) rd_data = cfg_r[i];
        end
        for (int i = 0; i < N_DBG; i++) begin
            if (roff == 8'(128 + i)) rd_data = dbg_r[i];
        end
    end

    // Read data is captured from pre-write state, so same-cycle read/write returns the old value.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            fx_q     <= '0;
            fx_q_vld <= 1'b0;
        end else begin
            fx_q     <= rsel ? rd_data : '0;
            fx_q_vld <= rsel;
        end
    end

    always_comb begin
        cfg_q = '0;
        for (int i = 0; i < N_CFG; i++) cfg_q[i*DW +: DW] = cfg_r[i];
    end

endmodule
